logic_unit_probe: RTL

- Sequential truth-table probe for a 2-input selectable logic unit: the OR/NOR unit steered by a select line.
- On `start`, it drives the unit's A, B and select inputs through all four operand combinations and samples the unit's output after a programmable settle time.
- It assembles a 4-bit truth table, classifies it as a named 2-input function, and flags whether that function matches the one the select value should produce.
- It sits on the unit's input side as its stimulus/decode partner, for self-check benches and lab boards.

---
 rtl/logic_unit_probe.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/logic_unit_probe.sv
// -----------------------------------------------------------------------------
// logic_unit_probe
//
// Sequential truth-table probe for a 2-input OR/NOR unit steered by a select
// line. On start it walks {a,b} through 00,01,10,11 with the latched select
// held on sel_out. Each vector is sampled SETTLE idle cycles after it is
// driven. The four samples form a truth table, which is classified as a named
// 2-input function and compared against the function the select should give.
//
// Parameters:
//   SETTLE     idle cycles between driving a vector and sampling y_in (0..15)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      probe request, accepted only when idle
//   sel_in     select value, latched when start is accepted
//   a_out      registered operand A to the unit
//   b_out      registered operand B to the unit
//   sel_out    registered select to the unit
//   y_in       unit output, combinational from a_out/b_out/sel_out
//   busy       high while a probe is in progress
//   done       one-cycle pulse when tt/func/match are valid
//   tt[3:0]    truth table, tt[{a,b}] = sampled y
//   func[2:0]  0 OTHER, 1 OR, 2 NOR, 3 AND, 4 NAND, 5 XOR, 6 XNOR, 7 CONST
//   match      func equals the expected function (sel=0: OR, sel=1: NOR)
//   err_count  (only with LOGIC_UNIT_PROBE_ERRCNT_EN) saturating count of
//              completed probes with match=0
//
// Optional feature macro: LOGIC_UNIT_PROBE_ERRCNT_EN
// -----------------------------------------------------------------------------
module logic_unit_probe #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sel_in,
    output logic       a_out,
    output logic       b_out,
    output logic       sel_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] tt,
    output logic [2:0] func,
    output logic       match
`ifdef LOGIC_UNIT_PROBE_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    localparam logic [2:0] FN_OTHER = 3'd0;
    localparam logic [2:0] FN_OR    = 3'd1;
    localparam logic [2:0] FN_NOR   = 3'd2;
    localparam logic [2:0] FN_AND   = 3'd3;
    localparam logic [2:0] FN_NAND  = 3'd4;
    localparam logic [2:0] FN_XOR   = 3'd5;
    localparam logic [2:0] FN_XNOR  = 3'd6;
    localparam logic [2:0] FN_CONST = 3'd7;

    // ST_NEXT is never occupied: its work is done on the sampling edge.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_NEXT,
        ST_FINISH
    } state_t;

    function automatic logic [2:0] classify(input logic [3:0] t);
        case (t)
            4'b1110:          return FN_OR;
            4'b0001:          return FN_NOR;
            4'b1000:          return FN_AND;
            4'b0111:          return FN_NAND;
            4'b0110:          return FN_XOR;
            4'b1001:          return FN_XNOR;
            4'b0000, 4'b1111: return FN_CONST;
            default:          return FN_OTHER;
        endcase
    endfunction

    state_t     r_state, w_state;
    logic [1:0] r_idx,   w_idx;
    logic [3:0] r_cnt,   w_cnt;
    logic       r_sel,   w_sel;
    logic [3:0] r_table, w_table;
    logic       r_a,     w_a;
    logic       r_b,     w_b;
    logic       r_sel_o, w_sel_o;
    logic       r_busy,  w_busy;
    logic       r_done,  w_done;
    logic [3:0] r_tt,    w_tt;
    logic [2:0] r_func,  w_func;
    logic       r_match, w_match;
    logic [2:0] w_class;
    logic [2:0] w_expect;
`ifdef LOGIC_UNIT_PROBE_ERRCNT_EN
    logic [7:0] r_err,   w_err;
`endif

    assign w_class  = classify(r_table);
    assign w_expect = r_sel ? FN_NOR : FN_OR;

    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_sel   = r_sel;
        w_table = r_table;
        w_a     = r_a;
        w_b     = r_b;
        w_sel_o = r_sel_o;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_tt    = r_tt;
        w_func  = r_func;
        w_match = r_match;
`ifdef LOGIC_UNIT_PROBE_ERRCNT_EN
        w_err   = r_err;
`endif

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_sel   = sel_in;
                    w_sel_o = sel_in;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                    w_idx   = 2'd0;
                    w_cnt   = 4'd0;
                    w_busy  = 1'b1;
                    w_state = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (r_cnt < SETTLE_CNT) begin
                    w_cnt = r_cnt + 4'd1;
                end else begin
                    w_table[r_idx] = y_in;
                    // Advance to the next vector on the same edge as the sample.
                    if (r_idx == 2'd3) begin
                        w_state = ST_FINISH;
                    end else begin
                        w_idx      = r_idx + 2'd1;
                        {w_a, w_b} = r_idx + 2'd1;
                        w_cnt      = 4'd0;
                    end
                end
            end

            ST_FINISH: begin
                w_tt    = r_table;
                w_func  = w_class;
                w_match = (w_class == w_expect);
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_a     = 1'b0;
                w_b     = 1'b0;
                w_sel_o = 1'b0;
                w_state = ST_IDLE;
`ifdef LOGIC_UNIT_PROBE_ERRCNT_EN
                if (w_class != w_expect && r_err != 8'hFF) begin
                    w_err = r_err + 8'd1;
                end
`endif
            end

            default: w_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_sel   <= 1'b0;
            r_table <= 4'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_sel_o <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tt    <= 4'd0;
            r_func  <= FN_OTHER;
            r_match <= 1'b0;
`ifdef LOGIC_UNIT_PROBE_ERRCNT_EN
            r_err   <= 8'd0;
`endif
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_sel   <= w_sel;
            r_table <= w_table;
            r_a     <= w_a;
            r_b     <= w_b;
            r_sel_o <= w_sel_o;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_tt    <= w_tt;
            r_func  <= w_func;
            r_match <= w_match;
`ifdef LOGIC_UNIT_PROBE_ERRCNT_EN
            r_err   <= w_err;
`endif
        end
    end

    assign a_out   = r_a;
    assign b_out   = r_b;
    assign sel_out = r_sel_o;
    assign busy    = r_busy;
    assign done    = r_done;
    assign tt      = r_tt;
    assign func    = r_func;
    assign match   = r_match;
`ifdef LOGIC_UNIT_PROBE_ERRCNT_EN
    assign err_count = r_err;
`endif

endmodule
